mod_multiply_arbiter: RTL and testbench

- Shares one external 2-stage FP16 multiplier among NUM_REQ requesters using round-robin arbitration.
- Accepts operand pairs and issues at most one per cycle to the multiplier.
- Tracks the owner of each in-flight operation through a tag pipeline and returns each result to its requester with an ID.
- Provides a drain control, used before reconfiguring the neural datapath, that stops new grants and reports when the multiplier is empty.

---
 rtl/mul_arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 30 +++
 rtl/mod_multiply_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mod_multiply_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types for the FP16 multiplier arbiter: FP16 field positions, FSM states
// and the tag that follows each operation through the multiplier pipeline.
package mul_arb_pkg;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MAN_W    = 10;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAINED
    } arb_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                zflag;
    } tag_t;

    function automatic logic expIsZero(input logic [15:0] x);
        return x[EXP_MSB:EXP_LSB] == '0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o
);

    logic         found;
    logic [W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_multiply_arbiter.sv
// Round-robin front end sharing one pipelined FP16 multiplier, with drain control.
// Optional MUL_ZERO_BYPASS_EN: zero-exponent operands yield a signed zero result.
module mod_multiply_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [15:0]           mul_a,
    output logic [15:0]           mul_b,
    output logic                  mul_en,
    input  logic [15:0]           mul_out,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_data,
    input  logic                  drain,
    output logic                  drained,
    output logic                  busy
);

    arb_state_e state_q, state_d;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] pickGrant;
    logic [ID_W-1:0]    pickIdx;
    logic               grantEnable;
    logic               transfer;
    logic [15:0]        selA, selB;

    logic [15:0]     mulA_q, mulB_q;
    logic            mulEn_q;
    logic [ID_W-1:0] issueId_q;
    logic            issueZflag;

    tag_t tag_q [MUL_LAT];

    logic            rspValid_q;
    logic [ID_W-1:0] rspId_q;
    logic [15:0]     rspData_q, rspData_d;
    logic            unusedTagBits;

    rr_pick #(
        .N(NUM_REQ),
        .W(ID_W)
    ) uPick (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .grant_o(pickGrant),
        .idx_o  (pickIdx)
    );

    assign req_ready = grantEnable ? pickGrant : '0;
    assign transfer  = |req_ready;

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            if (int'(pickIdx) == NUM_REQ - 1) ptr_d = '0;
            else                              ptr_d = pickIdx + 1'b1;
        end
    end

    always_comb begin
        selA = FP16_ZERO;
        selB = FP16_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickGrant[i]) begin
                selA = req_a[16*i +: 16];
                selB = req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        busy = mulEn_q;
        for (int i = 0; i < MUL_LAT; i++) busy = busy | tag_q[i].valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // Clearing drain always wins over finishing the drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain) state_d = DRAIN;
            DRAIN:   if (!drain) state_d = RUN;
                     else if (!busy) state_d = DRAINED;
            DRAINED: if (!drain) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        grantEnable = (state_q == RUN) && !drain;
        drained     = (state_q == DRAINED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            mulEn_q   <= 1'b0;
            mulA_q    <= FP16_ZERO;
            mulB_q    <= FP16_ZERO;
            issueId_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            mulEn_q <= transfer;
            if (transfer) begin
                mulA_q    <= selA;
                mulB_q    <= selB;
                issueId_q <= pickIdx;
            end
        end
    end

`ifdef MUL_ZERO_BYPASS_EN
    logic issueZ_q;
    logic issueSign_q;
    logic zSign_q [MUL_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issueZ_q    <= 1'b0;
            issueSign_q <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) zSign_q[i] <= 1'b0;
        end else begin
            if (transfer) begin
                issueZ_q    <= expIsZero(selA) | expIsZero(selB);
                issueSign_q <= selA[SIGN_BIT] ^ selB[SIGN_BIT];
            end
            zSign_q[0] <= issueSign_q;
            for (int i = 1; i < MUL_LAT; i++) zSign_q[i] <= zSign_q[i-1];
        end
    end

    assign issueZflag = issueZ_q;

    // The multiplier forces a hidden leading 1, so zero-exponent inputs are patched here.
    always_comb begin
        rspData_d = mul_out;
        if (tag_q[MUL_LAT-1].zflag) rspData_d = {zSign_q[MUL_LAT-1], 15'd0};
    end
`else
    assign issueZflag = 1'b0;

    always_comb begin
        rspData_d = mul_out;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: mulEn_q, id: TAG_ID_W'(issueId_q), zflag: issueZflag};
            for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
            rspData_q  <= FP16_ZERO;
        end else begin
            rspValid_q <= tag_q[MUL_LAT-1].valid;
            if (tag_q[MUL_LAT-1].valid) begin
                rspId_q   <= tag_q[MUL_LAT-1].id[ID_W-1:0];
                rspData_q <= rspData_d;
            end
        end
    end

    assign unusedTagBits = ^{tag_q[MUL_LAT-1].id, tag_q[MUL_LAT-1].zflag};

    assign mul_a     = mulA_q;
    assign mul_b     = mulB_q;
    assign mul_en    = mulEn_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;

endmodule

// File: tb/tb_mod_multiply_arbiter.sv
// Directed bench for mod_multiply_arbiter with a 2-stage FP16 multiplier model.
// Expected products come from a small truncating FP16 multiply of normal numbers.
module tb_mod_multiply_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*16-1:0] req_a = '0;
    logic [NUM_REQ*16-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           mul_a, mul_b;
    logic                  mul_en;
    logic [15:0]           mul_out = 16'h0;
    logic [15:0]           mulStage = 16'h0;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_data;
    logic                  drain = 1'b0;
    logic                  drained;
    logic                  busy;

    int compared   = 0;
    int mismatched = 0;

    mod_multiply_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .MUL_LAT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_en   (mul_en),
        .mul_out  (mul_out),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .drain    (drain),
        .drained  (drained),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fp16mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [6:0]  e;
        logic [9:0]  m;
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = 7'(a[14:10]) + 7'(b[14:10]) - 7'd15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 7'd1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    // Two-stage multiplier: operands seen in cycle n appear on mul_out in cycle n+2.
    always @(posedge clk) begin
        mulStage <= fp16mul(mul_a, mul_b);
        mul_out  <= mulStage;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [15:0] a,
                                 input logic [15:0] b);
        req_valid = valid;
        req_a     = {NUM_REQ{a}};
        req_b     = {NUM_REQ{b}};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic        sawRsp;
    logic [15:0] expZero;

    initial begin
        $display("[TB] start");
        #1;
        checkOutput("rst_ready",    32'(req_ready), 32'h0);
        checkOutput("rst_mul_en",   32'(mul_en),    32'h0);
        checkOutput("rst_mul_a",    32'(mul_a),     32'h0);
        checkOutput("rst_rsp",      32'(rsp_valid), 32'h0);
        checkOutput("rst_busy",     32'(busy),      32'h0);
        checkOutput("rst_drained",  32'(drained),   32'h0);
        tick();
        tick();
        rst = 1'b1;

        // All four requesters active: strict rotation, in-order responses.
        applyStimulus(4'b1111, 16'h3E00, 16'h3E00);
        for (int k = 0; k < 12; k++) begin
            if (k == 8) applyStimulus(4'b0000, 16'h3E00, 16'h3E00);
            #1;
            if (k < 8) checkOutput($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            else       checkOutput($sformatf("rr_idle%0d", k), 32'(req_ready), 32'h0);
            if (k >= 4) begin
                checkOutput($sformatf("rr_rsp_v%0d", k), 32'(rsp_valid), 32'h1);
                checkOutput($sformatf("rr_rsp_id%0d", k), 32'(rsp_id), 32'((k - 4) % 4));
                checkOutput($sformatf("rr_rsp_d%0d", k), 32'(rsp_data), 32'h4080);
            end
            tick();
        end
        checkOutput("rr_rsp_end", 32'(rsp_valid), 32'h0);

        // Single request from requester 2.
        applyStimulus(4'b0100, 16'h3C00, 16'h4000);
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        #1;
        checkOutput("single_ready_off", 32'(req_ready), 32'h0);
        checkOutput("single_mul_en", 32'(mul_en), 32'h1);
        checkOutput("single_mul_a",  32'(mul_a),  32'h3C00);
        checkOutput("single_mul_b",  32'(mul_b),  32'h4000);
        tick();
        checkOutput("single_mul_en_off", 32'(mul_en), 32'h0);
        checkOutput("single_busy", 32'(busy), 32'h1);
        tick();
        checkOutput("single_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("single_rsp_v",  32'(rsp_valid), 32'h1);
        checkOutput("single_rsp_id", 32'(rsp_id),    32'h2);
        checkOutput("single_rsp_d",  32'(rsp_data),  32'(fp16mul(16'h3C00, 16'h4000)));
        tick();
        checkOutput("single_rsp_off", 32'(rsp_valid), 32'h0);
        checkOutput("single_idle",    32'(busy),      32'h0);

        // Drain with two operations in flight; pointer sits at 3.
        applyStimulus(4'b0111, 16'h3C00, 16'h4000);
        #1;
        checkOutput("drn_grant0", 32'(req_ready), 32'h1);
        tick();
        checkOutput("drn_grant1", 32'(req_ready), 32'h2);
        tick();
        drain = 1'b1;
        #1;
        checkOutput("drn_stop",    32'(req_ready), 32'h0);
        checkOutput("drn_not_yet", 32'(drained),   32'h0);
        tick();
        checkOutput("drn_busy",    32'(busy),      32'h1);
        checkOutput("drn_rsp_pre", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("drn_rsp0_v",  32'(rsp_valid), 32'h1);
        checkOutput("drn_rsp0_id", 32'(rsp_id),    32'h0);
        tick();
        checkOutput("drn_rsp1_v",  32'(rsp_valid), 32'h1);
        checkOutput("drn_rsp1_id", 32'(rsp_id),    32'h1);
        checkOutput("drn_last_rsp_drained", 32'(drained), 32'h0);
        tick();
        checkOutput("drn_drained", 32'(drained),   32'h1);
        checkOutput("drn_rsp_end", 32'(rsp_valid), 32'h0);
        drain = 1'b0;
        #1;
        checkOutput("drn_release_ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("drn_drained_off", 32'(drained),   32'h0);
        checkOutput("drn_resume_ptr",  32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 5; k++) tick();

        // Drain while idle reaches DRAINED one cycle after DRAIN.
        drain = 1'b1;
        tick();
        checkOutput("idle_drain_1", 32'(drained), 32'h0);
        tick();
        checkOutput("idle_drain_2", 32'(drained), 32'h1);
        drain = 1'b0;
        tick();
        checkOutput("idle_drain_off", 32'(drained), 32'h0);

        // Reset with two operations in flight; pointer sits at 3.
        applyStimulus(4'b0011, 16'h4200, 16'h4400);
        #1;
        checkOutput("rmid_grant0", 32'(req_ready), 32'h1);
        tick();
        checkOutput("rmid_grant1", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        rst = 1'b0;
        #1;
        checkOutput("rmid_mul_en",  32'(mul_en),    32'h0);
        checkOutput("rmid_mul_a",   32'(mul_a),     32'h0);
        checkOutput("rmid_mul_b",   32'(mul_b),     32'h0);
        checkOutput("rmid_busy",    32'(busy),      32'h0);
        checkOutput("rmid_rsp_v",   32'(rsp_valid), 32'h0);
        checkOutput("rmid_rsp_d",   32'(rsp_data),  32'h0);
        checkOutput("rmid_drained", 32'(drained),   32'h0);
        tick();
        rst = 1'b1;
        sawRsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            sawRsp = sawRsp | rsp_valid;
        end
        checkOutput("rmid_no_rsp", 32'(sawRsp), 32'h0);
        applyStimulus(4'b1111, 16'h3C00, 16'h3C00);
        #1;
        checkOutput("rmid_first_grant", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 5; k++) tick();

        // Zero-exponent operand from requester 3 (pointer at 1).
`ifdef MUL_ZERO_BYPASS_EN
        expZero = 16'h8000;
`else
        expZero = fp16mul(16'h8000, 16'h4000);
`endif
        applyStimulus(4'b1000, 16'h8000, 16'h4000);
        #1;
        checkOutput("zero_ready", 32'(req_ready), 32'h8);
        tick();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        checkOutput("zero_rsp_v",  32'(rsp_valid), 32'h1);
        checkOutput("zero_rsp_id", 32'(rsp_id),    32'h3);
        checkOutput("zero_rsp_d",  32'(rsp_data),  32'(expZero));
        tick();
        tick();

        // Requester 1 alone issues five back-to-back pairs.
        applyStimulus(4'b0010, 16'h3C00, 16'h4000);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) req_valid = 4'b0000;
            #1;
            checkOutput($sformatf("b2b_ready%0d", k), 32'(req_ready), (k < 5) ? 32'h2 : 32'h0);
            if (k >= 4 && k < 9) begin
                checkOutput($sformatf("b2b_rsp_v%0d", k), 32'(rsp_valid), 32'h1);
                checkOutput($sformatf("b2b_rsp_id%0d", k), 32'(rsp_id), 32'h1);
                checkOutput($sformatf("b2b_rsp_d%0d", k), 32'(rsp_data), 32'h4000);
            end
            if (k == 9) checkOutput("b2b_rsp_end", 32'(rsp_valid), 32'h0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
